// File: rtl/mc_controller.sv
// Main control unit for the multicycle RV32I-subset core: a Moore FSM that sequences
// one instruction over 3-5 cycles, plus the ALU decoder fed from the FSM's ALU op.

module aludec (
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] ALUOp,
    output logic [2:0] ALUControl
);
    always_comb begin
        ALUControl = 3'b000;
        case (ALUOp)
            2'b00:   ALUControl = 3'b000;
            2'b01:   ALUControl = 3'b001;
            default: begin
                case (funct3)
                    // sub only for R-type; addi with imm[10]=1 must still add
                    3'b000:  ALUControl = (opb5 & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
        endcase
    end
endmodule

// state    | meaning
// FETCH    | read instr at PC into IR, PC <= PC+4
// DECODE   | read regs, branch target into ALUOut
// MEMADR   | compute load/store address
// MEMREAD  | read data memory at ALUOut
// MEMWB    | write loaded data to rd
// MEMWRITE | write rs2 to memory at ALUOut
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// ALUWB    | write ALUOut to rd
// BEQ      | compare rs1/rs2, take branch on Zero
// JAL      | PC <= target, rd value (OldPC+4) into ALUOut
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic       Illegal
);
    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BEQ      = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [3:0] state_out;
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       illegal_raw;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_R:         state_nxt = EXECR;
                    OP_I:         state_nxt = EXECI;
                    OP_BEQ:       state_nxt = BEQ;
                    OP_JAL:       state_nxt = JAL;
                    default:      state_nxt = FETCH;
                endcase
            end
            MEMADR:   state_nxt = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  state_nxt = MEMWB;
            MEMWB:    state_nxt = FETCH;
            MEMWRITE: state_nxt = FETCH;
            EXECR:    state_nxt = ALUWB;
            EXECI:    state_nxt = ALUWB;
            JAL:      state_nxt = ALUWB;
            ALUWB:    state_nxt = FETCH;
            BEQ:      state_nxt = FETCH;
            default:  state_nxt = FETCH;
        endcase
    end

    // Under reset the selects look like FETCH; the enables are gated off below.
    assign state_out = reset ? FETCH : state;

    always_comb begin
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        alu_op        = 2'b00;
        pc_update     = 1'b0;
        branch        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        case (state_out)
            FETCH: begin
                ir_write_raw = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                pc_update    = 1'b1;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: illegal_raw = 1'b0;
                    default:                                  illegal_raw = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            ALUWB: reg_write_raw = 1'b1;
            BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWrite  = ~reset & (pc_update | (branch & Zero));
    assign MemWrite = ~reset & mem_write_raw;
    assign IRWrite  = ~reset & ir_write_raw;
    assign RegWrite = ~reset & reg_write_raw;
    assign Illegal  = ~reset & illegal_raw;

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    aludec u_aludec (
        .opb5       (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .ALUOp      (alu_op),
        .ALUControl (ALUControl)
    );
endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: each driven cycle pushes the expected output
// vector, and a negedge monitor pops and compares it against the DUT.

module tb_mc_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MWR = 5;
    localparam int S_ER = 6, S_EI = 7, S_AWB = 8, S_BEQ = 9, S_JAL = 10;

    int n_cmp = 0;
    int n_mis = 0;
    string       tag_q[$];
    logic [16:0] exp_q[$];

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .ALUControl (ALUControl),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    wire [16:0] obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                       ImmSrc, RegWrite, ALUControl, Illegal};

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Vector layout: pcw adr mw irw rs[2] sa[2] sb[2] imm[2] rw aluc[3] ill
    function automatic logic [16:0] exp_vec(input int st, input bit rst, input logic [6:0] o,
                                            input logic [2:0] f3, input bit f7, input bit z);
        bit pcu = 0, br = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
        logic [1:0] rs = 2'b00, sa = 2'b00, sb = 2'b00, aop = 2'b00, imm;
        logic [2:0] aluc;
        bit supported;
        int s;
        supported = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
                    (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111);
        s = rst ? S_F : st;
        case (s)
            S_F:   begin irw = 1; sb = 2'b10; rs = 2'b10; pcu = 1; end
            S_D:   begin sa = 2'b01; sb = 2'b01; ill = !supported; end
            S_MA:  begin sa = 2'b10; sb = 2'b01; end
            S_MR:  adr = 1;
            S_MWB: begin rs = 2'b01; rw = 1; end
            S_MWR: begin adr = 1; mw = 1; end
            S_ER:  begin sa = 2'b10; aop = 2'b10; end
            S_EI:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            S_AWB: rw = 1;
            S_BEQ: begin sa = 2'b10; aop = 2'b01; br = 1; end
            S_JAL: begin sa = 2'b01; sb = 2'b10; pcu = 1; end
            default: ;
        endcase
        if (rst) begin pcu = 0; irw = 0; end
        if (o == 7'b0100011)      imm = 2'b01;
        else if (o == 7'b1100011) imm = 2'b10;
        else if (o == 7'b1101111) imm = 2'b11;
        else                      imm = 2'b00;
        if (aop == 2'b00)      aluc = 3'b000;
        else if (aop == 2'b01) aluc = 3'b001;
        else if (f3 == 3'b000) aluc = (o[5] && f7) ? 3'b001 : 3'b000;
        else if (f3 == 3'b010) aluc = 3'b101;
        else if (f3 == 3'b110) aluc = 3'b011;
        else if (f3 == 3'b111) aluc = 3'b010;
        else                   aluc = 3'b000;
        return {pcu | (br & z), adr, mw, irw, rs, sa, sb, imm, rw, aluc, ill};
    endfunction

    task automatic step(input string tag, input int st, input bit rst, input logic [6:0] o,
                        input logic [2:0] f3, input bit f7, input bit zfix, input bit zv);
        @(posedge clk);
        #1;
        reset    = rst;
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        Zero     = zfix ? zv : 1'($urandom_range(0, 1));
        tag_q.push_back(tag);
        exp_q.push_back(exp_vec(st, rst, o, f3, f7, Zero));
    endtask

    task automatic instr(input string nm, input logic [6:0] o, input logic [2:0] f3, input bit f7,
                         input bit z, input int n, input int s0, input int s1, input int s2,
                         input int s3, input int s4);
        int seq[5];
        seq = '{s0, s1, s2, s3, s4};
        for (int i = 0; i < n; i++)
            step($sformatf("%s.c%0d", nm, i + 1), seq[i], 1'b0, o, f3, f7, seq[i] == S_BEQ, z);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            string       t;
            logic [16:0] e;
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            chk_eq(t, {15'b0, obs}, {15'b0, e});
        end
    end

    initial begin
        step("rst.c1", S_F, 1'b1, 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
        step("rst.c2", S_F, 1'b1, 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);

        instr("lw",   7'b0000011, 3'b010, 1'b0, 1'b0, 5, S_F, S_D, S_MA, S_MR, S_MWB);
        instr("sw",   7'b0100011, 3'b010, 1'b0, 1'b0, 4, S_F, S_D, S_MA, S_MWR, S_F);
        instr("sub",  7'b0110011, 3'b000, 1'b1, 1'b0, 4, S_F, S_D, S_ER, S_AWB, S_F);
        instr("add",  7'b0110011, 3'b000, 1'b0, 1'b0, 4, S_F, S_D, S_ER, S_AWB, S_F);
        instr("addi", 7'b0010011, 3'b000, 1'b1, 1'b0, 4, S_F, S_D, S_EI, S_AWB, S_F);
        instr("slt",  7'b0110011, 3'b010, 1'b0, 1'b0, 4, S_F, S_D, S_ER, S_AWB, S_F);
        instr("or",   7'b0110011, 3'b110, 1'b0, 1'b0, 4, S_F, S_D, S_ER, S_AWB, S_F);
        instr("andi", 7'b0010011, 3'b111, 1'b0, 1'b0, 4, S_F, S_D, S_EI, S_AWB, S_F);
        instr("beqT", 7'b1100011, 3'b000, 1'b0, 1'b1, 3, S_F, S_D, S_BEQ, S_F, S_F);
        instr("beqN", 7'b1100011, 3'b000, 1'b0, 1'b0, 3, S_F, S_D, S_BEQ, S_F, S_F);
        instr("jal",  7'b1101111, 3'b000, 1'b0, 1'b0, 4, S_F, S_D, S_JAL, S_AWB, S_F);
        instr("ill",  7'b1111111, 3'b000, 1'b0, 1'b0, 2, S_F, S_D, S_F, S_F, S_F);
        instr("ill2", 7'b0000000, 3'b000, 1'b0, 1'b0, 2, S_F, S_D, S_F, S_F, S_F);

        // Reset asserted while in MEMREAD must abandon the load and restart at FETCH.
        instr("lwr",  7'b0000011, 3'b010, 1'b0, 1'b0, 3, S_F, S_D, S_MA, S_F, S_F);
        step("midrst.c1", S_MR, 1'b1, 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
        step("midrst.c2", S_F,  1'b1, 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
        instr("postrst_sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 4, S_F, S_D, S_MA, S_MWR, S_F);
        instr("lw2",  7'b0000011, 3'b010, 1'b0, 1'b0, 5, S_F, S_D, S_MA, S_MR, S_MWB);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        chk_eq("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
